// File: rtl/xdma_pkg.sv
// Shared types for the XDMA write-channel arbiter.
package xdma_pkg;

  typedef struct packed {
    logic [7:0] num_beats;
    logic       is_single;
    logic       is_write_data;
  } xdma_req_w_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } xdma_w_arb_state_e;

endpackage

// File: rtl/xdma_rr_picker.sv
// Rotate-priority picker: first valid requester at or above rr_ptr, with wrap.
module xdma_rr_picker #(
  parameter int NumReq = 2,
  parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_valid,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [IdxW-1:0]   pick,
  output logic              any_valid
);

  // Scan offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    logic [IdxW-1:0] sel;
    sel       = '0;
    pick      = '0;
    any_valid = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      sel = IdxW'((int'(rr_ptr) + i) % NumReq);
      if (req_valid[sel]) begin
        pick      = sel;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xdma_w_arbiter.sv
// Round-robin owner of the single XDMA write datapath.
// Optional perf counters are built when XDMA_W_ARB_PERF_EN is defined.
module xdma_w_arbiter
  import xdma_pkg::*;
#(
  parameter int  NumReq = 2,
  parameter type data_t = logic,
  parameter type desc_t = xdma_req_w_desc_t,
  parameter int  IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  desc_t [NumReq-1:0]       req_desc_i,
  input  logic  [NumReq-1:0]       req_valid_i,
  output logic  [NumReq-1:0]       req_ready_o,
  input  data_t [NumReq-1:0]       req_data_i,
  input  logic  [NumReq-1:0]       req_data_valid_i,
  output logic  [NumReq-1:0]       req_data_ready_o,
  input  logic  [NumReq-1:0]       req_grant_i,
  output desc_t                    dp_desc_o,
  output logic                     dp_valid_o,
  input  logic                     dp_ready_i,
  output data_t                    dp_data_o,
  output logic                     dp_data_valid_o,
  input  logic                     dp_data_ready_i,
  output logic                     dp_grant_o,
`ifdef XDMA_W_ARB_PERF_EN
  output logic  [NumReq-1:0][31:0] perf_bursts_o,
  output logic  [31:0]             perf_busy_cycles_o,
`endif
  output logic                     busy_o,
  output logic  [IdxW-1:0]         active_idx_o
);

  xdma_w_arb_state_e state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, idx_q, pick;
  logic              any_valid;
  desc_t             desc_q;
  logic              issue, done;

  xdma_rr_picker #(.NumReq(NumReq), .IdxW(IdxW)) u_picker (
    .req_valid (req_valid_i),
    .rr_ptr    (rr_ptr_q),
    .pick      (pick),
    .any_valid (any_valid)
  );

  assign issue = (state_q == ST_ISSUE);
  // A completion arriving alongside reset is swallowed: the burst is dropped.
  assign done  = issue && dp_ready_i && !rst_i;

  // State, owner, round-robin pointer and latched descriptor.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      desc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && any_valid) begin
        idx_q  <= pick;
        desc_q <= req_desc_i[pick];
      end
      if (done) rr_ptr_q <= (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Next state plus descriptor handshake and owner-routed data/grant.
  always_comb begin
    state_d          = state_q;
    dp_desc_o        = '0;
    dp_valid_o       = 1'b0;
    dp_data_o        = '0;
    dp_data_valid_o  = 1'b0;
    dp_grant_o       = 1'b0;
    busy_o           = 1'b0;
    active_idx_o     = '0;
    req_ready_o      = '0;
    req_data_ready_o = '0;
    case (state_q)
      ST_IDLE: if (any_valid) state_d = ST_ISSUE;
      ST_ISSUE: begin
        dp_valid_o              = 1'b1;
        dp_desc_o               = desc_q;
        busy_o                  = 1'b1;
        active_idx_o            = idx_q;
        dp_data_o               = req_data_i[idx_q];
        dp_data_valid_o         = req_data_valid_i[idx_q];
        dp_grant_o              = req_grant_i[idx_q];
        req_data_ready_o[idx_q] = dp_data_ready_i;
        req_ready_o[idx_q]      = done;
        if (dp_ready_i) state_d = ST_GAP;
      end
      // One dead cycle so the datapath never sees a stale valid descriptor.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef XDMA_W_ARB_PERF_EN
  // Saturating burst and busy-cycle counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_bursts_o      <= '0;
      perf_busy_cycles_o <= '0;
    end else begin
      if (issue && perf_busy_cycles_o != '1) perf_busy_cycles_o <= perf_busy_cycles_o + 32'd1;
      for (int i = 0; i < NumReq; i++)
        if (req_ready_o[i] && perf_bursts_o[i] != '1) perf_bursts_o[i] <= perf_bursts_o[i] + 32'd1;
    end
  end
`endif

endmodule
